// File: rtl/regfile_wb_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_if
// Bundle of issue, operand, writeback and load-port signals between the
// issue/ALU side (master) and the register file / writeback stage (slave).
//
// Signals (direction as seen by the slave, i.e. the register file):
//   in_valid   in   instruction presented this cycle
//   opcode     in   instruction opcode (also routed to the ALU)
//   addr_a/b   in   source register indices
//   addr_d     in   destination register index
//   rdata_a/b  out  combinational operands to the ALU
//   alu_result in   ALU result, valid the cycle after issue
//   alu_psr    in   ALU status flags, valid the cycle after issue
//   ld_valid   in   memory-stage load write request
//   ld_addr    in   load destination register
//   ld_data    in   load data
//   psr        out  committed processor status register
//   wb_valid   out  a writeback committed on the last edge
//   wb_addr    out  register written on the last edge
//   ld_drop    out  load lost a same-register collision on the last edge
// -----------------------------------------------------------------------------
interface regfile_wb_if #(
   parameter int AW = 4,
   parameter int DW = 16
);
   logic          in_valid;
   logic [7:0]    opcode;
   logic [AW-1:0] addr_a;
   logic [AW-1:0] addr_b;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] rdata_a;
   logic [DW-1:0] rdata_b;
   logic [DW-1:0] alu_result;
   logic [4:0]    alu_psr;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic [4:0]    psr;
   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic          ld_drop;

   modport slave (
      input  in_valid, opcode, addr_a, addr_b, addr_d,
      input  alu_result, alu_psr, ld_valid, ld_addr, ld_data,
      output rdata_a, rdata_b, psr, wb_valid, wb_addr, ld_drop
   );

   modport master (
      output in_valid, opcode, addr_a, addr_b, addr_d,
      output alu_result, alu_psr, ld_valid, ld_addr, ld_data,
      input  rdata_a, rdata_b, psr, wb_valid, wb_addr, ld_drop
   );
endinterface

// File: rtl/regfile_wb.sv
// -----------------------------------------------------------------------------
// regfile_wb
// Register file and writeback stage wrapped around a one-cycle registered ALU.
// Supplies ALU operands from an NREGS x DW register file with a bypass from
// the in-flight ALU result, tracks each instruction's destination across the
// ALU latency, commits the ALU result and PSR flags, and accepts a secondary
// load write from the memory stage.
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   bus    slave side of regfile_wb_if (issue, operands, ALU return,
//          load port, psr and writeback status)
// -----------------------------------------------------------------------------
module regfile_wb #(
   parameter int NREGS = 16,
   parameter int AW    = 4,
   parameter int DW    = 16
) (
   input  logic        clock,
   input  logic        reset,
   regfile_wb_if.slave bus
);

   // Stage register: what the instruction currently inside the ALU will do
   // when its result returns.
   logic          r_stg_wen;
   logic          r_stg_psr_en;
   logic [AW-1:0] r_stg_addr;

   // Committed state and writeback status.
   logic [4:0]    r_psr;
   logic          r_wb_valid;
   logic [AW-1:0] r_wb_addr;
   logic          r_ld_drop;

   // Decode of the instruction in the issue slot.
   logic          w_dec_wen;
   logic          w_dec_psr_en;

   // Writeback-edge controls.
   logic          w_alu_we;
   logic          w_collide;
   logic          w_ld_we;

   // Bypass selects and array read view.
   logic          w_byp_a;
   logic          w_byp_b;
   logic [DW-1:0] w_rf [NREGS];

   // ------------------------------------------------------------------
   // Opcode decode
   // ------------------------------------------------------------------
   always_comb begin
      w_dec_wen    = 1'b0;
      w_dec_psr_en = 1'b0;
      case (bus.opcode)
         8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0D: w_dec_wen = 1'b1;
         // Whole 0x8X and 0xFX groups write a destination.
         default: w_dec_wen = (bus.opcode[7:4] == 4'h8) ||
                              (bus.opcode[7:4] == 4'hF);
      endcase
      // ADD and CMP update the flags; CMP writes no register.
      if ((bus.opcode == 8'h05) || (bus.opcode == 8'h0B)) begin
         w_dec_psr_en = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Stage register, captured on the issue edge alongside the ALU.
   // A bubble captures no write and no flag update.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stg_wen    <= 1'b0;
         r_stg_psr_en <= 1'b0;
         r_stg_addr   <= '0;
      end else begin
         r_stg_wen    <= bus.in_valid & w_dec_wen;
         r_stg_psr_en <= bus.in_valid & w_dec_psr_en;
         r_stg_addr   <= bus.addr_d;
      end
   end

   // ------------------------------------------------------------------
   // Writeback arbitration. The ALU always wins a same-register collision
   // with the load port; collisions on r0 are irrelevant since neither
   // write lands there.
   // ------------------------------------------------------------------
   always_comb begin
      w_alu_we  = r_stg_wen && (r_stg_addr != '0);
      w_collide = r_stg_wen && bus.ld_valid &&
                  (bus.ld_addr == r_stg_addr) && (bus.ld_addr != '0);
      w_ld_we   = bus.ld_valid && (bus.ld_addr != '0) && !w_collide;
   end

   // ------------------------------------------------------------------
   // Register array. Entry 0 has no storage and reads as zero; every
   // other entry is a DW-bit register with ALU-over-load write priority.
   // ------------------------------------------------------------------
   assign w_rf[0] = '0;

   generate
      for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
         logic [DW-1:0] r_q;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               r_q <= '0;
            end else if (w_alu_we && (r_stg_addr == AW'(gi))) begin
               r_q <= bus.alu_result;
            end else if (w_ld_we && (bus.ld_addr == AW'(gi))) begin
               r_q <= bus.ld_data;
            end
         end

         assign w_rf[gi] = r_q;
      end
   endgenerate

   // ------------------------------------------------------------------
   // PSR and writeback status.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_psr      <= '0;
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_ld_drop  <= 1'b0;
      end else begin
         if (r_stg_psr_en) begin
            r_psr <= bus.alu_psr;
         end
         // A write aimed at r0 is discarded but still reported.
         r_wb_valid <= r_stg_wen;
         r_wb_addr  <= r_stg_addr;
         r_ld_drop  <= w_collide;
      end
   end

   // ------------------------------------------------------------------
   // Operand read with bypass. The stage holds at most one in-flight
   // write, which is always the youngest, so a single compare suffices.
   // Load writes never bypass; they become visible from the array.
   // ------------------------------------------------------------------
   always_comb begin
      w_byp_a = r_stg_wen && (r_stg_addr != '0) && (bus.addr_a == r_stg_addr);
      w_byp_b = r_stg_wen && (r_stg_addr != '0) && (bus.addr_b == r_stg_addr);
   end

   always_comb begin
      bus.rdata_a = '0;
      bus.rdata_b = '0;
      // Operands are forced to zero while reset is held.
      if (reset) begin
         bus.rdata_a = w_byp_a ? bus.alu_result : w_rf[bus.addr_a];
         bus.rdata_b = w_byp_b ? bus.alu_result : w_rf[bus.addr_b];
      end
   end

   assign bus.psr      = r_psr;
   assign bus.wb_valid = r_wb_valid;
   assign bus.wb_addr  = r_wb_addr;
   assign bus.ld_drop  = r_ld_drop;

endmodule

// File: tb/tb_regfile_wb.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb
// Self-checking bench for regfile_wb: directed sequences for the pipeline,
// bypass, PSR, collision, r0 and mid-flight reset cases; a table of opcode
// decode vectors; and a randomized run against a reference model.
// -----------------------------------------------------------------------------
module tb_regfile_wb;
   localparam int AW = 4;
   localparam int DW = 16;

   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   regfile_wb_if #(.AW(AW), .DW(DW)) bus ();

   regfile_wb #(.NREGS(16), .AW(AW), .DW(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.in_valid   = 1'b0;
      bus.opcode     = 8'h00;
      bus.addr_a     = '0;
      bus.addr_b     = '0;
      bus.addr_d     = '0;
      bus.alu_result = '0;
      bus.alu_psr    = '0;
      bus.ld_valid   = 1'b0;
      bus.ld_addr    = '0;
      bus.ld_data    = '0;
   endtask

   task automatic issue(input logic [7:0] op, input int a, input int b, input int d);
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.addr_a   = 4'(a);
      bus.addr_b   = 4'(b);
      bus.addr_d   = 4'(d);
   endtask

   task automatic rd(input int a, input int b);
      bus.addr_a = 4'(a);
      bus.addr_b = 4'(b);
   endtask

   // Which opcodes write a register / update the flags.
   function automatic bit spec_writes(input logic [7:0] op);
      return (op inside {8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0D}) ||
             (op[7:4] == 4'h8) || (op[7:4] == 4'hF);
   endfunction

   function automatic bit spec_psr(input logic [7:0] op);
      return (op == 8'h05) || (op == 8'h0B);
   endfunction

   typedef struct {
      logic [7:0]  op;
      logic [15:0] data;
      logic [4:0]  apsr;
      logic        wen;
      logic [4:0]  exp_psr;
   } vec_t;

   vec_t vecs [17];

   // Reference model state for the randomized run.
   logic [15:0] mregs [16];
   logic [4:0]  mpsr;
   bit          p_wen, p_psr;
   logic [3:0]  p_addr;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] exp_r9;
      logic [7:0]  ops [12];
      logic [15:0] exp_a, exp_b;
      bit          exp_wbv, exp_drop, collide;
      logic [3:0]  exp_wba;

      vecs[0]  = '{8'h01, 16'h1111, 5'h01, 1'b1, 5'h00};
      vecs[1]  = '{8'h05, 16'h2222, 5'h03, 1'b1, 5'h03};
      vecs[2]  = '{8'h0B, 16'h3333, 5'h04, 1'b0, 5'h04};
      vecs[3]  = '{8'h44, 16'h4444, 5'h05, 1'b0, 5'h04};
      vecs[4]  = '{8'h8A, 16'h5555, 5'h06, 1'b1, 5'h04};
      vecs[5]  = '{8'hF3, 16'h6666, 5'h07, 1'b1, 5'h04};
      vecs[6]  = '{8'h0D, 16'h7777, 5'h08, 1'b1, 5'h04};
      vecs[7]  = '{8'h07, 16'h8888, 5'h09, 1'b0, 5'h04};
      vecs[8]  = '{8'h02, 16'h9999, 5'h0A, 1'b1, 5'h04};
      vecs[9]  = '{8'h03, 16'hAAAA, 5'h0B, 1'b1, 5'h04};
      vecs[10] = '{8'h09, 16'hBBBB, 5'h0C, 1'b1, 5'h04};
      vecs[11] = '{8'h7F, 16'hCCCC, 5'h0D, 1'b0, 5'h04};
      vecs[12] = '{8'h0B, 16'hDDDD, 5'h15, 1'b0, 5'h15};
      vecs[13] = '{8'hE0, 16'hEEEE, 5'h16, 1'b0, 5'h15};
      vecs[14] = '{8'h9F, 16'h1357, 5'h17, 1'b0, 5'h15};
      vecs[15] = '{8'h8F, 16'h2468, 5'h18, 1'b1, 5'h15};
      vecs[16] = '{8'hF0, 16'hACE1, 5'h19, 1'b1, 5'h15};

      // ---------------- reset then read ----------------
      idle();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rd(i, 15 - i);
         #1;
         chk("reset_rdata_a", 32'(bus.rdata_a), 32'h0);
         chk("reset_rdata_b", 32'(bus.rdata_b), 32'h0);
      end
      chk("reset_psr", 32'(bus.psr), 32'h0);
      chk("reset_wb_valid", 32'(bus.wb_valid), 32'h0);
      chk("reset_ld_drop", 32'(bus.ld_drop), 32'h0);
      tick();

      // ---------------- loads then ADDU, bypass chain ----------------
      bus.ld_valid = 1'b1; bus.ld_addr = 4'd1; bus.ld_data = 16'h1234;
      tick();
      bus.ld_addr = 4'd2; bus.ld_data = 16'h0101;
      tick();
      bus.ld_valid = 1'b0;
      issue(8'h06, 1, 2, 3);
      #1;
      chk("addu_rdata_a", 32'(bus.rdata_a), 32'h1234);
      chk("addu_rdata_b", 32'(bus.rdata_b), 32'h0101);
      tick();
      issue(8'h06, 3, 3, 4);
      bus.alu_result = 16'h1335; bus.alu_psr = 5'h1F;
      #1;
      chk("bypass_rdata_a", 32'(bus.rdata_a), 32'h1335);
      chk("bypass_rdata_b", 32'(bus.rdata_b), 32'h1335);
      tick();
      chk("addu_wb_valid", 32'(bus.wb_valid), 32'h1);
      chk("addu_wb_addr", 32'(bus.wb_addr), 32'h3);
      chk("addu_psr_kept", 32'(bus.psr), 32'h0);
      bus.in_valid = 1'b0;
      bus.alu_result = 16'h266A;
      rd(3, 3);
      #1;
      chk("r3_committed", 32'(bus.rdata_a), 32'h1335);
      tick();
      chk("chain_wb_valid", 32'(bus.wb_valid), 32'h1);
      chk("chain_wb_addr", 32'(bus.wb_addr), 32'h4);
      rd(3, 4);
      #1;
      chk("r3_after", 32'(bus.rdata_a), 32'h1335);
      chk("r4_committed", 32'(bus.rdata_b), 32'h266A);
      tick();
      chk("bubble_wb_valid", 32'(bus.wb_valid), 32'h0);

      // ---------------- CMP / PSR ----------------
      issue(8'h0B, 1, 2, 5);
      tick();
      bus.in_valid = 1'b0;
      bus.alu_result = 16'hDEAD; bus.alu_psr = 5'b01010;
      rd(5, 5);
      #1;
      chk("cmp_no_bypass", 32'(bus.rdata_a), 32'h0);
      tick();
      chk("cmp_psr", 32'(bus.psr), 32'h0A);
      chk("cmp_wb_valid", 32'(bus.wb_valid), 32'h0);
      chk("cmp_r5_unwritten", 32'(bus.rdata_a), 32'h0);

      // ---------------- load/ALU collision ----------------
      issue(8'h06, 1, 2, 5);
      tick();
      bus.in_valid = 1'b0;
      bus.alu_result = 16'h0042;
      bus.ld_valid = 1'b1; bus.ld_addr = 4'd5; bus.ld_data = 16'hBEEF;
      tick();
      bus.ld_valid = 1'b0;
      chk("coll_ld_drop", 32'(bus.ld_drop), 32'h1);
      chk("coll_wb_valid", 32'(bus.wb_valid), 32'h1);
      chk("coll_wb_addr", 32'(bus.wb_addr), 32'h5);
      rd(5, 0);
      #1;
      chk("coll_r5", 32'(bus.rdata_a), 32'h0042);
      tick();
      chk("coll_ld_drop_clear", 32'(bus.ld_drop), 32'h0);

      issue(8'h06, 1, 2, 5);
      tick();
      bus.in_valid = 1'b0;
      bus.alu_result = 16'h0077;
      bus.ld_valid = 1'b1; bus.ld_addr = 4'd6; bus.ld_data = 16'hBEEF;
      tick();
      bus.ld_valid = 1'b0;
      chk("nocoll_ld_drop", 32'(bus.ld_drop), 32'h0);
      rd(5, 6);
      #1;
      chk("nocoll_r5", 32'(bus.rdata_a), 32'h0077);
      chk("nocoll_r6", 32'(bus.rdata_b), 32'hBEEF);
      chk("psr_held", 32'(bus.psr), 32'h0A);

      // ---------------- write to r0 ----------------
      issue(8'h01, 0, 0, 0);
      tick();
      bus.in_valid = 1'b0;
      bus.alu_result = 16'hFFFF;
      rd(0, 0);
      #1;
      chk("r0_no_bypass", 32'(bus.rdata_a), 32'h0);
      tick();
      chk("r0_wb_valid", 32'(bus.wb_valid), 32'h1);
      chk("r0_wb_addr", 32'(bus.wb_addr), 32'h0);
      chk("r0_reads_zero", 32'(bus.rdata_a), 32'h0);

      // ---------------- reset mid-flight ----------------
      issue(8'h06, 1, 2, 7);
      tick();
      bus.in_valid = 1'b0;
      bus.alu_result = 16'h5555; bus.alu_psr = 5'h1F;
      rd(7, 3);
      #1;
      chk("midrst_bypass", 32'(bus.rdata_a), 32'h5555);
      #1;
      reset = 1'b0;
      #1;
      chk("midrst_rdata_a", 32'(bus.rdata_a), 32'h0);
      chk("midrst_rdata_b", 32'(bus.rdata_b), 32'h0);
      chk("midrst_psr", 32'(bus.psr), 32'h0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("midrst_r7", 32'(bus.rdata_a), 32'h0);
      chk("midrst_wb_valid", 32'(bus.wb_valid), 32'h0);
      tick();
      chk("midrst_no_commit", 32'(bus.wb_valid), 32'h0);
      chk("midrst_r7_after", 32'(bus.rdata_a), 32'h0);
      idle();

      // ---------------- opcode decode table ----------------
      exp_r9 = 16'h0;
      for (int i = 0; i < 17; i++) begin
         issue(vecs[i].op, 0, 0, 9);
         tick();
         bus.in_valid   = 1'b0;
         bus.alu_result = vecs[i].data;
         bus.alu_psr    = vecs[i].apsr;
         tick();
         chk($sformatf("vec%0d_wb_valid", i), 32'(bus.wb_valid), 32'(vecs[i].wen));
         chk($sformatf("vec%0d_psr", i), 32'(bus.psr), 32'(vecs[i].exp_psr));
         if (vecs[i].wen) exp_r9 = vecs[i].data;
         rd(9, 9);
         #1;
         chk($sformatf("vec%0d_r9", i), 32'(bus.rdata_a), 32'(exp_r9));
      end

      // ---------------- randomized run against reference model ----------------
      idle();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
      mpsr = 5'h0; p_wen = 1'b0; p_psr = 1'b0; p_addr = 4'h0;
      ops = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0D,
              8'h0B, 8'h44, 8'h80, 8'hF7, 8'h00};

      for (int c = 0; c < 600; c++) begin
         bus.in_valid   = ($urandom_range(0, 3) != 0);
         bus.opcode     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 11)];
         bus.addr_a     = 4'($urandom_range(0, 7));
         bus.addr_b     = 4'($urandom_range(0, 15));
         bus.addr_d     = 4'($urandom_range(0, 7));
         bus.ld_valid   = ($urandom_range(0, 2) == 0);
         bus.ld_addr    = 4'($urandom_range(0, 7));
         bus.ld_data    = 16'($urandom);
         bus.alu_result = 16'($urandom);
         bus.alu_psr    = 5'($urandom);
         #1;
         // The youngest pending write to a nonzero register overrides the file.
         exp_a = (p_wen && p_addr != 0 && p_addr == bus.addr_a) ? bus.alu_result : mregs[bus.addr_a];
         exp_b = (p_wen && p_addr != 0 && p_addr == bus.addr_b) ? bus.alu_result : mregs[bus.addr_b];
         chk("rand_rdata_a", 32'(bus.rdata_a), 32'(exp_a));
         chk("rand_rdata_b", 32'(bus.rdata_b), 32'(exp_b));

         // Edge effects.
         collide  = p_wen && bus.ld_valid && (bus.ld_addr == p_addr) && (p_addr != 0);
         exp_wbv  = p_wen;
         exp_wba  = p_addr;
         exp_drop = collide;
         if (p_wen && p_addr != 0) mregs[p_addr] = bus.alu_result;
         if (bus.ld_valid && !collide && bus.ld_addr != 0) mregs[bus.ld_addr] = bus.ld_data;
         if (p_psr) mpsr = bus.alu_psr;
         p_wen  = bus.in_valid && spec_writes(bus.opcode);
         p_psr  = bus.in_valid && spec_psr(bus.opcode);
         p_addr = bus.addr_d;

         tick();
         chk("rand_psr", 32'(bus.psr), 32'(mpsr));
         chk("rand_wb_valid", 32'(bus.wb_valid), 32'(exp_wbv));
         if (exp_wbv) chk("rand_wb_addr", 32'(bus.wb_addr), 32'(exp_wba));
         chk("rand_ld_drop", 32'(bus.ld_drop), 32'(exp_drop));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Register file and writeback stage around the 16-bit ALU.
- Supplies the ALU's A/B operands from a 16x16 register file, with a bypass from the in-flight ALU result.
- Tracks each instruction's destination across the ALU's one-cycle registered latency, then commits the ALU result and PSR flags.
- Also accepts a secondary load-write port from the memory stage.

Parameters:
- NREGS, 16, number of architectural registers
- AW, 4, register address width (log2 NREGS)
- DW, 16, data width (matches ALU result/rdata width)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction presented this cycle (issue slot)
- opcode  in  8  instruction opcode, also routed unchanged to ALU
- addr_a  in  AW  source A register index
- addr_b  in  AW  source B register index
- addr_d  in  AW  destination register index
- rdata_a  out  DW  operand A to ALU (combinational)
- rdata_b  out  DW  operand B to ALU (combinational)
- alu_result  in  DW  ALU result, valid the cycle after issue
- alu_psr  in  5  ALU PSR, valid the cycle after issue
- ld_valid  in  1  memory-stage load write request
- ld_addr  in  AW  load destination
- ld_data  in  DW  load data
- psr  out  5  committed processor status register
- wb_valid  out  1  registered: a writeback committed on the last edge
- wb_addr  out  AW  registered: register written on the last edge
- ld_drop  out  1  registered: load write lost a collision on the last edge

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, pipeline valid 0, psr 0, wb_valid 0, wb_addr 0, ld_drop 0.
  - rdata_a and rdata_b read 0 while reset is held.
- Register 0 always reads 0; writes to it are discarded (no error, wb_valid still pulses).
- Writeback decode (registered at issue edge when in_valid=1):
  - Writes: opcode 0x01, 0x02, 0x03, 0x05, 0x06, 0x09, 0x0D, any 0x8X, any 0xFX.
  - No write: 0x0B (CMP), 0x44 (STORE), all others.
  - PSR commit: opcode 0x05 (ADD) and 0x0B (CMP).
- Pipeline timing, instruction issued in cycle N:
  - Edge ending N: stage register captures {wen, psr_en, addr_d}; the ALU captures its result on the same edge.
  - Cycle N+1: alu_result and alu_psr are valid.
  - Edge ending N+1: if wen, regs[addr_d] <= alu_result; if psr_en, psr <= alu_psr; wb_valid <= wen, wb_addr <= addr_d.
  - Total latency: 2 edges from issue to architectural commit.
- Bypass:
  - Applies in cycle N+1 when the stage has wen=1, stage addr != 0, and addr_a (or addr_b) equals the stage addr.
  - The corresponding rdata output is driven from alu_result instead of the array.
  - Instruction at N+2 or later reads the array normally.
- in_valid=0: bubble. The stage captures wen=0 and psr_en=0, and the ALU output is ignored next cycle.
- Back-to-back writes to the same register: both commit in order; the bypass always uses the youngest in-flight (stage) value.
- Load port: ld_valid=1 writes ld_data to ld_addr at the edge, in parallel with the ALU writeback.
  - Same-edge collision (same nonzero addr): the ALU write wins, the load is dropped, and ld_drop pulses 1 for one cycle.
  - Different addresses: both write.
  - A load write does not feed the bypass; it is visible from the next cycle.
- Reset asserted mid-operation: the in-flight stage is cleared immediately; the pending result is never committed, even if alu_result is valid.
- Widths: all data is exactly DW bits, with no extension or truncation. psr is a 5-bit straight copy.

Test Plan:
- Reset then read: hold reset=0 for 3 clocks, release; read every addr_a/addr_b -> rdata=0x0000; psr=0; wb_valid=0.
- Load then ADDU: ld r1=0x1234 and ld r2=0x0101 (separate cycles), then issue 0x06 A=r1 B=r2 D=r3 -> rdata_a=0x1234, rdata_b=0x0101; two edges later r3=0x1335, wb_valid=1, wb_addr=3; psr unchanged.
- Bypass chain: issue ADDU r3=r1+r2, next cycle issue 0x06 A=r3 B=r3 D=r4 -> rdata_a=rdata_b=0x1335 via bypass; r4=0x266A committed.
- CMP/PSR: issue 0x0B with r1, r2 and drive alu_psr=5'b01010 next cycle -> psr=5'b01010, no register written, wb_valid=0.
- Collision: ALU writeback to r5 and ld_valid to r5 (ld_data=0xBEEF, alu_result=0x0042) on the same edge -> r5=0x0042, ld_drop=1 for one cycle.
  - Repeat with ld_addr=r6 -> both written, ld_drop=0.
- r0 and reset mid-flight: issue MOV to r0 -> r0 still reads 0.
  - Issue ADDU to r7, assert reset during cycle N+1 -> r7=0 after release, psr=0, wb_valid=0.
